// File: rtl/hamming_serial_tx.sv
// hamming_serial_tx: splits a data word into nibbles and encodes each one as
// Hamming(7,4). The frame goes out on one serial line as a start bit (0), the
// 7*blocks code bits and a stop bit (1). Each bit is held for div clock cycles.
module hamming_serial_tx #(
  parameter int width = 4,
  parameter int div   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             frame_done
);

  localparam int BLOCKS = width / 4;
  localparam int NBITS  = 7 * BLOCKS;
  localparam int BIT_W  = $clog2(NBITS + 1);
  localparam int DIV_W  = (div > 1) ? $clog2(div) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(div - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       r_state;
  logic [NBITS-1:0] r_shift;      // captured code bits, next bit to send in [0]
  logic [BIT_W-1:0] r_bit_cnt;    // index of the DATA bit currently on the line
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tx;
  logic             r_frame_done;

  logic [NBITS-1:0] w_frame;      // encoded word in transmit order, LSB first
  logic             w_tick;       // last cycle of the current bit period

  // Encoder: per nibble the order on the line is d0..d3 then p1, p2, p3.
  generate
    for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_enc
      logic [3:0] w_nib;
      assign w_nib = in_data[gi*4 +: 4];
      assign w_frame[gi*7 +: 7] = {w_nib[0] ^ w_nib[1] ^ w_nib[2],   // p3
                                   w_nib[0] ^ w_nib[1] ^ w_nib[3],   // p2
                                   w_nib[0] ^ w_nib[2] ^ w_nib[3],   // p1
                                   w_nib};                           // d3..d0
    end
  endgenerate

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign in_ready   = (r_state == IDLE);
  assign tx_busy    = (r_state != IDLE);
  assign tx_out     = r_tx;
  assign frame_done = r_frame_done;

  // Bit-period counter: idles at zero and restarts at every bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if ((r_state == IDLE) || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Frame sequencer: tx_out is registered, so each bit is loaded one edge
  // ahead of the cycle it appears on the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state   <= START;
            r_shift   <= w_frame;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_tx.sv
// tb_hamming_serial_tx: four instances with different width/div settings.
// A per-instance scoreboard queues the expected per-cycle line state when a
// word is accepted and compares it against the outputs every cycle.
module tb_hamming_serial_tx;

  localparam int NDUT = 4;
  localparam int W_TAB [NDUT] = '{4, 4, 8, 16};
  localparam int D_TAB [NDUT] = '{1, 3, 1, 1};

  logic        clk;
  logic        rst;
  logic        in_valid   [NDUT];
  logic        in_ready   [NDUT];
  logic [15:0] in_data    [NDUT];
  logic        tx_out     [NDUT];
  logic        tx_busy    [NDUT];
  logic        frame_done [NDUT];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    else
      n_pass++;
  endtask

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int W  = W_TAB[gi];
      localparam int D  = D_TAB[gi];
      localparam int NB = W / 4;

      hamming_serial_tx #(.width(W), .div(D)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .in_data   (in_data[gi][W-1:0]),
        .tx_out    (tx_out[gi]),
        .tx_busy   (tx_busy[gi]),
        .frame_done(frame_done[gi])
      );

      // entry = {busy, frame_done, tx_out}; an empty queue means idle line
      logic [2:0] exp_q [$];

      always @(negedge clk) begin
        logic [2:0] e;
        logic [3:0] nib;
        logic [6:0] grp;
        if (!rst) begin
          exp_q.delete();
          e = 3'b001;
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
        end else begin
          e = 3'b001;
        end
        check($sformatf("tx_out%0d", gi),     tx_out[gi],     e[0]);
        check($sformatf("tx_busy%0d", gi),    tx_busy[gi],    e[2]);
        check($sformatf("frame_done%0d", gi), frame_done[gi], e[1]);
        check($sformatf("in_ready%0d", gi),   in_ready[gi],   !e[2]);
        if (rst && in_valid[gi] && in_ready[gi]) begin
          for (int k = 0; k < D; k++) exp_q.push_back(3'b100);
          for (int b = 0; b < NB; b++) begin
            nib = in_data[gi][4*b +: 4];
            grp = {nib[0] ^ nib[1] ^ nib[2], nib[0] ^ nib[1] ^ nib[3],
                   nib[0] ^ nib[2] ^ nib[3], nib};
            for (int k = 0; k < 7; k++)
              for (int r = 0; r < D; r++) exp_q.push_back({2'b10, grp[k]});
          end
          for (int k = 0; k < D; k++) exp_q.push_back(3'b101);
          exp_q.push_back(3'b011);
        end
      end
    end
  endgenerate

  // Waits for the instance to be ready, then presents one word for one edge.
  // Returns 1 time unit after the accepting edge (first start-bit cycle).
  task automatic send(input int idx, input logic [15:0] d);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!in_ready[idx] && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check($sformatf("ready_wait%0d", idx), (t < 1000), 1);
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]   bits9;
    logic [15:0]  bits16;
    logic [111:0] rx;
    logic [6:0]   g;
    logic [2:0]   syn;
    logic [15:0]  w;
    logic [15:0]  dec;
    int busy_cnt;
    int fd_cnt;

    for (int i = 0; i < NDUT; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_tx%0d", i),    tx_out[i],     1);
      check($sformatf("rst_ready%0d", i), in_ready[i],   1);
      check($sformatf("rst_busy%0d", i),  tx_busy[i],    0);
      check($sformatf("rst_fd%0d", i),    frame_done[i], 0);
    end
    rst = 1'b1;

    // width=4, div=1, word 1011
    send(0, 16'h000B);
    bits9 = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      bits9 = {bits9[7:0], tx_out[0]};
    end
    check("frame_1011", bits9, 9'b0_1101010_1);
    @(negedge clk);
    check("fd_1011", frame_done[0], 1);

    // width=8, div=1, word F0
    send(2, 16'h00F0);
    bits16 = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bits16 = {bits16[14:0], tx_out[2]};
    end
    check("frame_F0", bits16, 16'b0_0000000_1111111_1);
    @(negedge clk);
    check("fd_F0", frame_done[2], 1);

    // width=4, div=3, word 1011: 27 busy cycles, one pulse
    send(1, 16'h000B);
    busy_cnt = 0;
    fd_cnt   = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_busy[1])    busy_cnt++;
      if (frame_done[1]) fd_cnt++;
    end
    check("busy_len_div3", busy_cnt, 27);
    check("fd_count_div3", fd_cnt, 1);

    // in_valid held high with in_data changing every cycle
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      in_data[0] = 16'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    repeat (15) @(posedge clk);

    // reset during DATA bit 3 (d3 of 0111 is 0)
    send(0, 16'h0007);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_d3", tx_out[0], 0);
    rst = 1'b0;
    #1;
    check("abort_tx",    tx_out[0],     1);
    check("abort_ready", in_ready[0],   1);
    check("abort_busy",  tx_busy[0],    0);
    check("abort_fd",    frame_done[0], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0005;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    check("accept_after_rst", tx_busy[0], 1);
    repeat (12) @(posedge clk);

    // loopback at width=16: syndrome of every 7-bit group must be zero
    for (int n = 0; n < 100; n++) begin
      w = 16'($urandom_range(0, 65535));
      send(3, w);
      @(negedge clk);
      rx = '0;
      for (int k = 0; k < 112; k++) begin
        @(negedge clk);
        rx[k] = tx_out[3];
      end
      dec = '0;
      for (int b = 0; b < 4; b++) begin
        g   = rx[7*b +: 7];
        syn = {g[6] ^ g[0] ^ g[1] ^ g[2],
               g[5] ^ g[0] ^ g[1] ^ g[3],
               g[4] ^ g[0] ^ g[2] ^ g[3]};
        check($sformatf("syndrome_w%0d_b%0d", n, b), syn, 0);
        dec[4*b +: 4] = g[3:0];
      end
      check($sformatf("loopback_data%0d", n), dec, w);
    end

    repeat (40) @(posedge clk);
    #1;
    check("drain0", g_dut[0].exp_q.size(), 0);
    check("drain1", g_dut[1].exp_q.size(), 0);
    check("drain2", g_dut[2].exp_q.size(), 0);
    check("drain3", g_dut[3].exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hamming_serial_tx.md
HAMMING_SERIAL_TX -- requirements
Module: hamming_serial_tx

Interface
REQ-001 The block SHALL have parameter width, default 4, data word width; legal values are multiples of 4 (4, 8, 16, 32...).
REQ-002 The block SHALL have parameter div, default 1, clock cycles per transmitted bit; legal values are 1 or greater.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data holds a word to transmit.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port in_data, input, width bits: data word, driven by the shift register's parallel_out.
REQ-008 The block SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port tx_busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame ends.

Function
REQ-011 The block SHALL split the word into blocks = width/4 nibbles; nibble i = in_data[i*4 +: 4], with bits d0..d3 = nibble[0..3].
REQ-012 Each nibble's parity SHALL be computed as p1 = d0^d2^d3, p2 = d0^d1^d3, p3 = d0^d1^d2.
REQ-013 Parity SHALL be computed at word capture and stored; changes on in_data after capture SHALL NOT affect the frame.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-015 A transfer SHALL occur only on a clock edge where in_valid=1 and in_ready=1; at that edge, latch the word and parities and go IDLE->START.
REQ-016 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored, with no queuing.
REQ-017 In START, tx_out SHALL be 0 for div cycles; then go to DATA.
REQ-018 In DATA, the block SHALL send 7*blocks bits, each held div cycles, with tx_out registered.
REQ-019 DATA bit order SHALL be block 0 first, and within each block d0, d1, d2, d3, p1, p2, p3.
REQ-020 After the last DATA bit the block SHALL go to STOP; tx_out SHALL be 1 for div cycles.
REQ-021 At the end of STOP the block SHALL return to IDLE and assert frame_done for exactly that one cycle (the first IDLE cycle).
REQ-022 Frame length SHALL be (2 + 7*blocks)*div cycles.
REQ-023 The first start-bit cycle SHALL be the cycle immediately after the accepting edge.
REQ-024 Back-to-back frames: in_ready=1 during the IDLE cycle after STOP, so the minimum gap between frames is one idle cycle with tx_out=1.
REQ-025 tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 The bit counter SHALL be sized $clog2(7*blocks+1) or larger and SHALL NOT wrap mid-frame.
REQ-027 The div counter SHALL run from 0 to div-1 and clear at each bit boundary.
REQ-028 With div=1, no div-counter stall cycles SHALL be inserted.

Reset
REQ-029 While rst=0, asynchronously: state=IDLE, tx_out=1, in_ready=1, tx_busy=0, frame_done=0, and all counters and the data/parity latches cleared.
REQ-030 Reset mid-frame SHALL abort the frame immediately; no frame_done pulse; line returns high.
REQ-031 After rst deasserts, a word SHALL be accepted on the first edge with in_valid=1.

Verification
REQ-032 width=4, div=1, in_data=4'b1011 accepted -> tx_out over 9 cycles = 0,1,1,0,1,0,1,0,1; frame_done pulses on the 10th cycle.
REQ-033 width=8, div=1, in_data=8'hF0 -> tx_out = 0, 0000000, 1111111, 1 (16 cycles).
REQ-034 width=4, div=3, in_data=4'b1011 -> each bit held 3 cycles; tx_busy high 27 cycles; frame_done once.
REQ-035 in_valid held high, in_data changed every cycle during a frame -> frame matches the captured word; in_ready=0 throughout; next word accepted in the IDLE cycle after STOP.
REQ-036 rst pulled low during DATA bit 3 -> tx_out=1, in_ready=1, tx_busy=0 immediately; no frame_done.
REQ-037 Loopback: tx_out deserialized and each 7-bit group fed to syndrome_calc -> syndrome=0 for 100 random words at width=16.
